// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns raw PS/2 scan-code bytes into whole key events (make/break,
// extended or not, plus the Pause key) and queues them in a small
// show-ahead FIFO drained by the host with a valid/ack handshake.
//
// Ports:
//   i_clock       system clock, rising edge
//   reset         asynchronous active-high reset
//   scan_ready    byte strobe from the PS/2 receiver (PS/2 clock domain)
//   scan_code     receiver byte, stable while scan_ready is high and after
//   key_ack       pops the FIFO head when key_valid is high
//   overflow_clr  clears the sticky overflow flag
//   key_valid     FIFO not empty; head event is on key_code/extended/released
//   key_code      head event code byte (E1 for Pause)
//   key_extended  head event carried the E0 prefix
//   key_released  head event carried the F0 prefix
//   overflow      sticky: an event was dropped because the FIFO was full
module ps2_key_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic       i_clock,
  input  logic       reset,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  input  logic       key_ack,
  input  logic       overflow_clr,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  typedef struct packed {
    logic [7:0] code;
    logic       extended;
    logic       released;
  } key_event_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  // Bytes that carry no key information and cancel any pending prefix.
  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // ---------------------------------------------------------------------
  // scan_ready synchronizer and rising-edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   sync_out;
  logic                   primed;
  logic                   strobe_c;
  logic                   strobe_q;
  logic [7:0]             byte_q;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign primed   = fill_q[SYNC_STAGES-1];
  assign strobe_c = sync_out & ~prev_q;

  // fill_q marks when the chain holds real samples rather than reset zeros;
  // until then prev_q is pinned high so a level held across reset is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_ready};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_out | ~primed;
    end
  end

  // Byte capture; scan_code is long stable by the time the strobe arrives.
  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      byte_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_c;
      if (strobe_c) begin
        byte_q <= scan_code;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Prefix-stripping FSM
  // ---------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [2:0] skip_q;
  logic [2:0] skip_d;
  logic       push_c;
  key_event_t push_event_c;

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    push_c       = 1'b0;
    push_event_c = '0;
    if (strobe_q) begin
      if (state_q == ST_PAUSE) begin
        // Pause is an 8-byte sequence with no break; swallow the 7 tail bytes.
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          push_c                = 1'b1;
          push_event_c.code     = CODE_PAUSE;
          push_event_c.extended = 1'b0;
          push_event_c.released = 1'b0;
          state_d               = ST_IDLE;
        end
      end else if (byte_q == CODE_EXT) begin
        state_d = ST_EXT;
      end else if (byte_q == CODE_BRK) begin
        if ((state_q == ST_EXT) || (state_q == ST_EXT_BRK)) begin
          state_d = ST_EXT_BRK;
        end else begin
          state_d = ST_BRK;
        end
      end else if (byte_q == CODE_PAUSE) begin
        state_d = ST_PAUSE;
        skip_d  = 3'd7;
      end else if (is_filler(byte_q)) begin
        state_d = ST_IDLE;
      end else begin
        push_c                = 1'b1;
        push_event_c.code     = byte_q;
        push_event_c.extended = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        push_event_c.released = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        state_d               = ST_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead event FIFO
  // ---------------------------------------------------------------------
  key_event_t          mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic                empty_c;
  logic                full_c;
  logic                pop_c;
  logic                write_c;
  logic                drop_c;
  key_event_t          head_c;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign pop_c   = key_ack & ~empty_c;
  // A pop in the same cycle frees the slot the push writes into.
  assign write_c = push_c & (~full_c | pop_c);
  assign drop_c  = push_c & full_c & ~pop_c;
  assign head_c  = mem_q[rd_ptr_q[PW-2:0]];

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (write_c) begin
        mem_q[wr_ptr_q[PW-2:0]] <= push_event_c;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  assign key_valid    = ~empty_c;
  assign key_code     = head_c.code;
  assign key_extended = head_c.extended;
  assign key_released = head_c.released;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives scan bytes as a slow strobe,
// checks decoded events, FIFO ordering, overflow and reset behaviour.
module tb_ps2_key_decoder;

  logic       i_clock;
  logic       reset;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       key_ack;
  logic       overflow_clr;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  ps2_key_decoder #(.SYNC_STAGES(2), .FIFO_AW(2)) dut (
    .i_clock      (i_clock),
    .reset        (reset),
    .scan_ready   (scan_ready),
    .scan_code    (scan_code),
    .key_ack      (key_ack),
    .overflow_clr (overflow_clr),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_released (key_released),
    .overflow     (overflow)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One byte: scan_ready high 8 cycles, then a quiet gap. key_valid is
  // sampled 3 and 4 cycles after the raw rise; the FSM push lands between
  // them, so ack/clr requested for the push are held across that edge.
  task automatic send_byte(input logic [7:0] b, input bit ack_push, input bit clr_push,
                           output logic v3, output logic v4);
    @(negedge i_clock);
    scan_code  = b;
    scan_ready = 1'b1;
    repeat (3) @(negedge i_clock);
    v3           = key_valid;
    key_ack      = ack_push;
    overflow_clr = clr_push;
    @(negedge i_clock);
    v4           = key_valid;
    key_ack      = 1'b0;
    overflow_clr = 1'b0;
    repeat (4) @(negedge i_clock);
    scan_ready = 1'b0;
    repeat (12) @(negedge i_clock);
  endtask

  task automatic send(input logic [7:0] b);
    logic v3, v4;
    send_byte(b, 1'b0, 1'b0, v3, v4);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] code, input logic ext,
                            input logic rel);
    @(negedge i_clock);
    check_eq({tag, "_valid"}, 32'(key_valid), 32'd1);
    check_eq({tag, "_event"}, 32'({key_code, key_extended, key_released}),
             32'({code, ext, rel}));
    key_ack = 1'b1;
    @(negedge i_clock);
    key_ack = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    @(negedge i_clock);
    check_eq({tag, "_empty"}, 32'(key_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge i_clock);
    reset = 1'b1;
    @(negedge i_clock);
    reset = 1'b0;
  endtask

  logic v3, v4;

  initial begin
    reset        = 1'b1;
    scan_ready   = 1'b0;
    scan_code    = 8'h00;
    key_ack      = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) @(negedge i_clock);
    check_eq("rst_valid", 32'(key_valid), 32'd0);
    check_eq("rst_code", 32'(key_code), 32'd0);
    check_eq("rst_ext", 32'(key_extended), 32'd0);
    check_eq("rst_rel", 32'(key_released), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge i_clock);

    // Plain make then break, with latency on the make.
    send_byte(8'h1C, 1'b0, 1'b0, v3, v4);
    check_eq("lat_before", 32'(v3), 32'd0);
    check_eq("lat_at", 32'(v4), 32'd1);
    pop_expect("make_1c", 8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    expect_empty("brk_prefix");
    send(8'h1C);
    pop_expect("break_1c", 8'h1C, 1'b0, 1'b1);
    expect_empty("plain_done");

    // Extended make and break.
    send(8'hE0);
    expect_empty("ext_prefix");
    send(8'h75);
    pop_expect("ext_make", 8'h75, 1'b1, 1'b0);
    send(8'hE0);
    send(8'hF0);
    expect_empty("ext_brk_prefix");
    send(8'h75);
    pop_expect("ext_break", 8'h75, 1'b1, 1'b1);
    expect_empty("ext_done");

    // Pause sequence followed by a plain make.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    pop_expect("pause", 8'hE1, 1'b0, 1'b0);
    pop_expect("after_pause", 8'h1C, 1'b0, 1'b0);
    expect_empty("pause_done");

    // Fillers, including one aborting an E0 prefix.
    send(8'hAA); send(8'hFA); send(8'hE0); send(8'hFE);
    expect_empty("fillers");
    send(8'h29);
    pop_expect("after_fill", 8'h29, 1'b0, 1'b0);
    expect_empty("fill_done");

    // Overflow with depth 4.
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_head", 32'(key_code), 32'h15);
    @(negedge i_clock); overflow_clr = 1'b1;
    @(negedge i_clock); overflow_clr = 1'b0;
    check_eq("ovf_clr", 32'(overflow), 32'd0);
    send_byte(8'h35, 1'b1, 1'b0, v3, v4);
    check_eq("full_push_pop", 32'(overflow), 32'd0);
    send_byte(8'h3C, 1'b0, 1'b1, v3, v4);
    check_eq("set_wins", 32'(overflow), 32'd1);
    @(negedge i_clock); overflow_clr = 1'b1;
    @(negedge i_clock); overflow_clr = 1'b0;
    check_eq("ovf_clr2", 32'(overflow), 32'd0);
    pop_expect("q0", 8'h1D, 1'b0, 1'b0);
    pop_expect("q1", 8'h24, 1'b0, 1'b0);
    pop_expect("q2", 8'h2D, 1'b0, 1'b0);
    pop_expect("q3", 8'h35, 1'b0, 1'b0);
    expect_empty("q_done");

    // Ack while empty is ignored; push+pop while empty keeps the push.
    @(negedge i_clock); key_ack = 1'b1;
    @(negedge i_clock); key_ack = 1'b0;
    expect_empty("ack_empty");
    send_byte(8'h4B, 1'b1, 1'b0, v3, v4);
    pop_expect("push_pop_empty", 8'h4B, 1'b0, 1'b0);
    expect_empty("pp_done");

    // Reset discards a pending prefix.
    send(8'hE0);
    pulse_reset();
    send(8'h1C);
    pop_expect("rst_mid", 8'h1C, 1'b0, 1'b0);
    expect_empty("rst_mid_done");

    // scan_ready held high through reset release gives no strobe.
    @(negedge i_clock);
    scan_code  = 8'h5A;
    scan_ready = 1'b1;
    reset      = 1'b1;
    @(negedge i_clock);
    reset = 1'b0;
    repeat (10) @(negedge i_clock);
    scan_ready = 1'b0;
    repeat (12) @(negedge i_clock);
    expect_empty("held_high");
    send(8'h1C);
    pop_expect("after_held", 8'h1C, 1'b0, 1'b0);
    expect_empty("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Turns the raw PS/2 scan-code bytes from the PS/2 receiver into whole key events: make or break, extended or not, plus the Pause key. It sits directly downstream of the receiver, on the system clock. It brings the receiver's byte strobe into this clock domain and strips the E0/F0/E1 prefixes. Decoded events are buffered in a small show-ahead FIFO that the host drains with a valid/ack handshake.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in the `scan_ready` synchronizer; minimum 2.
- `FIFO_AW`, default 2: event FIFO address width, giving a depth of 2^`FIFO_AW` (default 4).

- `i_clock`  in  1  system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `scan_ready`  in  1  byte strobe from the PS/2 receiver, in the PS/2 clock domain. It is high for about one PS/2 bit time.
- `scan_code`  in  8  byte from the receiver; stable while `scan_ready` is high and for at least one PS/2 bit time after.
- `key_ack`  in  1  pops the FIFO head when `key_valid` is high.
- `overflow_clr`  in  1  clears `overflow`.
- `key_valid`  out  1  FIFO is not empty; the head event is on the `key_*` outputs.
- `key_code`  out  8  head event's code byte (E1 for Pause).
- `key_extended`  out  1  head event had the E0 prefix.
- `key_released`  out  1  head event had the F0 prefix (break).
- `overflow`  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- **Reset values:** all outputs are 0, the FIFO is empty, the FSM is in IDLE, and the synchronizer flops are 0.
  - The edge-detect "previous" flop resets to 1. A `scan_ready` held high across reset therefore produces no strobe.
- **Strobe:** a strobe fires when the synchronized `scan_ready` is 1 and the previous flop is 0. On a strobe, `scan_code` is latched into the byte register.
- **FSM states:** IDLE, EXT, BRK, EXT_BRK, PAUSE. Each strobed byte is handled as follows, in the state shown:
  - E0 (any state except PAUSE): go to EXT.
  - F0 in IDLE or BRK: go to BRK.
  - F0 in EXT or EXT_BRK: go to EXT_BRK.
  - E1 (any state except PAUSE): go to PAUSE, with the skip counter (3 bits) set to 7.
  - Filler codes 00, AA, EE, FA, FE, FF (any state except PAUSE): go to IDLE with no event.
  - Any other byte: push an event {code = byte, extended = state is EXT or EXT_BRK, released = state is BRK or EXT_BRK} and go to IDLE.
  - In PAUSE, every byte is discarded and decrements the counter. The byte that takes the counter from 1 to 0 pushes {E1, 0, 0} and returns to IDLE.
- **FIFO:** show-ahead (first-word fall-through). The head event is presented whenever `key_valid` is 1.
  - Pop happens when `key_ack` and `key_valid` are both 1. `key_ack` while empty is ignored.
  - Push while full with no pop in the same cycle: the event is dropped, `overflow` is set, and the FIFO contents are unchanged.
  - Push and pop together while full: both take effect; no overflow.
  - Push and pop together while empty: the push happens; the pop is ignored.
  - Pointers are `FIFO_AW`+1 bits wide and wrap modulo 2^(`FIFO_AW`+1). Full means the MSBs differ and the rest are equal.
- **`overflow`:** `overflow_clr` clears it. If a set and a clear happen in the same cycle, set wins.
- **Reset mid-sequence:** a pending prefix or Pause count is discarded. The next byte is decoded from IDLE.

## Timing
- **Cycle S:** the first cycle the synchronizer output is 1.
  - The strobe is combinational in S.
  - At the end of S, the byte register loads and the strobe register sets.
- **Cycle S+1:** the FSM acts on the registered byte. At the end of S+1, the state updates and any push is written.
- **Cycle S+2:** `key_valid` goes to 1 if the FIFO was empty.
- **Latency:** from the raw `scan_ready` rise to `key_valid`, at most `SYNC_STAGES`+3 cycles.
- **Pop:** with `key_ack` high in cycle N, the next event (or `key_valid` = 0) appears in N+1.
- **`overflow`:** rises in the cycle after the dropped push.
- **Strobe spacing:** consecutive strobes are at least about 11 PS/2 bit times apart, so one byte register is enough. No back-pressure goes to the receiver.

## Test plan
- **Plain make then break:** bytes 1C, then F0 1C. Expected: event {1C,0,0}, then {1C,0,1}. `key_valid` rises exactly 2 cycles after the synchronized strobe.
- **Extended key:** bytes E0 75, then E0 F0 75. Expected: {75,1,0}, then {75,1,1}. Prefix bytes alone produce no event.
- **Pause key:** bytes E1 14 77 E1 F0 14 F0 77, then 1C. Expected: exactly {E1,0,0} followed by {1C,0,0}. The E1/F0 bytes inside the sequence are not decoded.
- **Fillers:** bytes AA, FA, then E0 FE, then 29. Expected: only {29,0,0}; the FE abort leaves the 29 non-extended.
- **Overflow (default depth 4):**
  - Send 5 makes (codes 15, 1D, 24, 2D, 2C) with `key_ack` held low. Expected: `overflow`=1, and the four queued events are 15, 1D, 24, 2D in order.
  - Then assert `key_ack` in the same cycle as a 6th push. Expected: no further overflow; the 6th event lands at the tail.
  - Then pulse `overflow_clr`. Expected: `overflow`=0.
- **Reset mid-sequence:**
  - Send E0, assert `reset` for 1 cycle, then send 1C. Expected: {1C,0,0}.
  - Hold `scan_ready`=1 through reset deassertion. Expected: no event.
